// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU initiator and data_mem_responder.
// The req_be byte-strobe signal exists only when BYTE_STROBE_EN is defined.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
`ifdef BYTE_STROBE_EN
        output req_be,
`endif
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
`ifdef BYTE_STROBE_EN
        input  req_be,
`endif
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with WAIT_CYCLES wait states and big-endian storage.
// Optional macro BYTE_STROBE_EN adds per-byte store enables (req_be).
module data_mem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 2
) (
    input logic CLK,
    input logic Reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [DEPTH_BYTES];

    logic [3:0]    reqBe;
    logic [AW-1:0] base;
    logic          reqErr;
    logic          enterResp;
    logic [31:0]   memWord;

`ifdef BYTE_STROBE_EN
    assign reqBe = bus.req_be;
`else
    assign reqBe = 4'hF;
`endif

    // The full 32-bit compare keeps high addresses from aliasing into the array.
    assign reqErr    = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD);
    assign base      = {addr_q[AW-1:2], 2'b00};
    assign enterResp = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign memWord   = {mem_q[base], mem_q[base + AW'(1)],
                        mem_q[base + AW'(2)], mem_q[base + AW'(3)]};

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset; a store commits only on the RESP entry edge.
    always_ff @(posedge CLK) begin
        if (Reset && enterResp && we_q && !reqErr) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[3-k]) begin
                    mem_q[base + AW'(k)] <= wdata_q[31-8*k -: 8];
                end
            end
        end
    end

    // Counter starts at WAIT_CYCLES so rsp_valid rises WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = reqBe;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = reqErr;
                    rdata_d = (we_q || reqErr) ? 32'd0 : memWord;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with two wait states, one with none.
// Build with BYTE_STROBE_EN defined to also exercise the byte-strobe stores.
module tb_data_mem_responder;
    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t expQ2[$];
    rsp_t expQ0[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   acceptCyc [2];
    int   riseCyc   [2];
    logic prevValid [2] = '{1'b0, 1'b0};
`ifdef BYTE_STROBE_EN
    logic [3:0] curBe = 4'hF;
`endif

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );
    data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .bus(bus0)
    );

    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic readyOf(input int which);
        return (which == 0) ? bus.req_ready : bus0.req_ready;
    endfunction

    function automatic logic validOf(input int which);
        return (which == 0) ? bus.rsp_valid : bus0.rsp_valid;
    endfunction

    task automatic driveReq(input int which, input logic v, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (which == 0) begin
            bus.req_valid = v;  bus.req_we = we;  bus.req_addr = addr;  bus.req_wdata = wdata;
`ifdef BYTE_STROBE_EN
            bus.req_be = curBe;
`endif
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr; bus0.req_wdata = wdata;
`ifdef BYTE_STROBE_EN
            bus0.req_be = curBe;
`endif
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic applyStimulus(input int which, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expErr, input bit pushExp);
        int   waited = 0;
        rsp_t e;
        driveReq(which, 1'b1, we, addr, wdata);
        while (readyOf(which) !== 1'b1 && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (readyOf(which) !== 1'b1) begin
            failNow("accept_timeout");
            driveReq(which, 1'b0, we, addr, wdata);
            return;
        end
        if (pushExp) begin
            e.rdata = expRdata;
            e.err   = expErr;
            if (which == 0) expQ2.push_back(e);
            else            expQ0.push_back(e);
        end
        @(posedge CLK);
        @(negedge CLK);
        acceptCyc[which] = cyc;
        driveReq(which, 1'b0, we, addr, wdata);
    endtask

    task automatic waitRsp(input int which);
        int waited = 0;
        while (validOf(which) !== 1'b1 && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (validOf(which) !== 1'b1) failNow("rsp_timeout");
    endtask

    task automatic waitIdle(input int which);
        int waited = 0;
        while (readyOf(which) !== 1'b1 && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (readyOf(which) !== 1'b1) failNow("idle_timeout");
    endtask

    task automatic monitorOne(input int which);
        rsp_t        e;
        logic        v, r, err;
        logic [31:0] rd;
        v   = (which == 0) ? bus.rsp_valid : bus0.rsp_valid;
        r   = (which == 0) ? bus.rsp_ready : bus0.rsp_ready;
        rd  = (which == 0) ? bus.rsp_rdata : bus0.rsp_rdata;
        err = (which == 0) ? bus.rsp_err   : bus0.rsp_err;
        if (v === 1'b1 && prevValid[which] !== 1'b1) riseCyc[which] = cyc;
        prevValid[which] = v;
        if (v === 1'b1 && r === 1'b1) begin
            if ((which == 0 && expQ2.size() == 0) || (which == 1 && expQ0.size() == 0)) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rsp dut%0d: rdata 0x%08h err %0b, nothing expected",
                         which, rd, err);
            end else begin
                e = (which == 0) ? expQ2.pop_front() : expQ0.pop_front();
                checkOutput((which == 0) ? "rsp_rdata_w2" : "rsp_rdata_w0", rd, e.rdata);
                checkOutput((which == 0) ? "rsp_err_w2" : "rsp_err_w0", 32'(err), 32'(e.err));
            end
        end
    endtask

    // Monitor samples 1 time unit after the falling edge so same-edge stimulus has settled.
    always begin
        @(negedge CLK);
        #1;
        monitorOne(0);
        monitorOne(1);
    end

    initial begin
        int base;
        Reset = 1'b0;
        driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
        driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.rsp_ready  = 1'b0;
        bus0.rsp_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;

        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
            checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end

        $display("[TB] store/load with two wait states");
        bus.rsp_ready = 1'b1;
        applyStimulus(0, 1'b1, 32'h10, 32'h12345678, 32'd0, 1'b0, 1'b1);
        waitRsp(0);
        checkOutput("latency_w2", 32'(cyc - acceptCyc[0]), 32'd3);
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h12345678, 1'b0, 1'b1);
        waitIdle(0);
        checkOutput("mem_byte_10", 32'(dut.mem_q[16]), 32'h12);
        checkOutput("mem_byte_13", 32'(dut.mem_q[19]), 32'h78);

        $display("[TB] error and boundary addresses");
        applyStimulus(0, 1'b1, 32'h14, 32'h0BADF00D, 32'd0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 32'h7C, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h7C, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h80, 32'd0, 32'd0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 32'h12, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 32'h90, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h12345678, 1'b0, 1'b1);
        waitIdle(0);

        $display("[TB] response backpressure");
        bus.rsp_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'h12345678, 1'b0, 1'b1);
        waitRsp(0);
        driveReq(0, 1'b1, 1'b0, 32'h14, 32'd0);
        repeat (5) begin
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_rsp_rdata", bus.rsp_rdata, 32'h12345678);
            checkOutput("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge CLK);
        end
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        base = cyc;
        checkOutput("bp_release_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        expQ2.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("bp_reaccept_gap", 32'(cyc - base), 32'd1);
        checkOutput("bp_reaccepted", 32'(bus.req_ready), 32'd0);
        acceptCyc[0] = cyc;
        driveReq(0, 1'b0, 1'b0, 32'h14, 32'd0);
        waitRsp(0);
        checkOutput("bp_latency", 32'(cyc - acceptCyc[0]), 32'd3);
        waitIdle(0);

        $display("[TB] zero wait states, back-to-back loads");
        applyStimulus(1, 1'b1, 32'h0, 32'h11223344, 32'd0, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 32'h4, 32'h55667788, 32'd0, 1'b0, 1'b1);
        waitIdle(1);
        applyStimulus(1, 1'b0, 32'h0, 32'd0, 32'h11223344, 1'b0, 1'b1);
        base = acceptCyc[1];
        applyStimulus(1, 1'b0, 32'h4, 32'd0, 32'h55667788, 1'b0, 1'b1);
        checkOutput("w0_accept_gap", 32'(acceptCyc[1] - base), 32'd3);
        checkOutput("w0_first_latency", 32'(riseCyc[1] - base), 32'd1);
        waitRsp(1);
        checkOutput("w0_second_latency", 32'(cyc - acceptCyc[1]), 32'd1);
        waitIdle(1);

        $display("[TB] reset during a pending store");
        applyStimulus(0, 1'b1, 32'h20, 32'h00000000, 32'd0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 32'h20, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        repeat (6) begin
            checkOutput("rst_drop_valid", 32'(bus.rsp_valid), 32'd0);
            checkOutput("rst_drop_ready", 32'(bus.req_ready), 32'd1);
            @(negedge CLK);
        end
        applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'h00000000, 1'b0, 1'b1);
        waitIdle(0);

`ifdef BYTE_STROBE_EN
        $display("[TB] byte strobes");
        curBe = 4'b0101;
        applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 32'd0, 1'b0, 1'b1);
        curBe = 4'hF;
        applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'h00BB00DD, 1'b0, 1'b1);
        curBe = 4'b0000;
        applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1);
        curBe = 4'hF;
        applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'h00BB00DD, 1'b0, 1'b1);
        waitIdle(0);
`endif

        waitIdle(0);
        waitIdle(1);
        repeat (2) @(negedge CLK);
        checkOutput("scoreboard_pending", 32'(expQ2.size() + expQ0.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
